// File: rtl/ysyx_22041752_pkg.sv
// Shared AXI geometry and responder state encoding for the ysyx_22041752 core.
package ysyx_22041752_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_LEN_W  = 8;
    localparam int BEAT_BYTES = AXI_DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4
    } axi_state_t;

endpackage

// File: rtl/ysyx_22041752_axi_sram_slave.sv
// AXI4 INCR-burst responder in front of a single-port SRAM, one transaction at a time.
// Writes go to SRAM in the W beat cycle; reads take 2 cycles/beat; valids hold until their handshake.
module ysyx_22041752_axi_sram_slave
    import ysyx_22041752_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int ID_W   = AXI_ID_W
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_W-1:0]       awid,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [AXI_LEN_W-1:0]  awlen,

    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,

    output logic                  bvalid,
    input  logic                  bready,
    output logic [ID_W-1:0]       bid,

    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_W-1:0]       arid,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [AXI_LEN_W-1:0]  arlen,

    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rlast,

    output logic                  sram_ren,
    output logic [ADDR_W-1:0]     sram_raddr,
    input  logic [DATA_W-1:0]     sram_rdata,
    output logic [DATA_W/8-1:0]   sram_wen,
    output logic [ADDR_W-1:0]     sram_waddr,
    output logic [DATA_W-1:0]     sram_wdata
);

    localparam logic [ADDR_W-1:0] BEAT_INC   = ADDR_W'(BEAT_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BEAT_BYTES - 1);

    axi_state_t             state, state_nxt;
    logic [ID_W-1:0]        cur_id;
    logic [ADDR_W-1:0]      cur_addr;
    logic [AXI_LEN_W-1:0]   cur_len;
    logic [AXI_LEN_W-1:0]   beat_cnt;
    logic                   rd_prio;

    logic                   aw_go, ar_go, w_go, r_go, beat_last;

    // Burst length is tracked by our own counter; wlast carries no information we act on.
    logic                   unused_wlast;
    assign unused_wlast = wlast;

    assign beat_last = (beat_cnt == cur_len);
    assign aw_go     = awvalid & awready;
    assign ar_go     = arvalid & arready;
    assign w_go      = wvalid & wready;
    assign r_go      = rvalid & rready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ar_go) begin
                    state_nxt = ST_RD_REQ;
                end else if (aw_go) begin
                    state_nxt = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (w_go && beat_last) begin
                    state_nxt = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                state_nxt = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (rready) begin
                    state_nxt = beat_last ? ST_IDLE : ST_RD_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Everything is gated by reset so the reset cycle itself presents an idle, silent port.
    always_comb begin
        awready    = 1'b0;
        arready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        bid        = cur_id;
        rvalid     = 1'b0;
        rid        = cur_id;
        rdata      = sram_rdata;
        rlast      = beat_last;
        sram_ren   = 1'b0;
        sram_raddr = cur_addr;
        sram_wen   = '0;
        sram_waddr = cur_addr;
        sram_wdata = wdata;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    arready = !(awvalid && !rd_prio);
                    awready = !(arvalid && rd_prio);
                end
                ST_WR_DATA: begin
                    wready = 1'b1;
                    if (wvalid) begin
                        sram_wen = wstrb;
                    end
                end
                ST_WR_RESP: bvalid   = 1'b1;
                ST_RD_REQ:  sram_ren = 1'b1;
                ST_RD_RESP: rvalid   = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_id   <= '0;
            cur_addr <= '0;
            cur_len  <= '0;
            beat_cnt <= '0;
            rd_prio  <= 1'b1;
        end else begin
            if (ar_go || aw_go) begin
                rd_prio <= ~rd_prio;
            end
            if (ar_go) begin
                cur_id   <= arid;
                cur_addr <= araddr & ALIGN_MASK;
                cur_len  <= arlen;
                beat_cnt <= '0;
            end else if (aw_go) begin
                cur_id   <= awid;
                cur_addr <= awaddr & ALIGN_MASK;
                cur_len  <= awlen;
                beat_cnt <= '0;
            end else if (w_go || (r_go && !beat_last)) begin
                cur_addr <= cur_addr + BEAT_INC;
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/ysyx_22041752_axi_sram_slave.md
YSYX_22041752_AXI_SRAM_SLAVE -- requirements
Module: ysyx_22041752_axi_sram_slave

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, byte address width; DATA_W, 64, beat width; ID_W, 4, transaction ID width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  clock
 reset  in  1  synchronous, active-high
 awvalid/awready  in/out  1/1  AW handshake
 awid/awaddr/awlen  in  ID_W/ADDR_W/8  write ID, start address, beats-1
 wvalid/wready  in/out  1/1  W handshake
 wdata/wstrb/wlast  in  DATA_W/8/1  write beat
 bvalid/bready/bid  out/in/out  1/1/ID_W  write response
 arvalid/arready  in/out  1/1  AR handshake
 arid/araddr/arlen  in  ID_W/ADDR_W/8  read ID, start address, beats-1
 rvalid/rready  out/in  1/1  R handshake
 rid/rdata/rlast  out  ID_W/DATA_W/1  read beat
 sram_ren/sram_raddr  out  1/ADDR_W  SRAM read request
 sram_rdata  in  DATA_W  SRAM read data, valid cycle after sram_ren, held until next sram_ren
 sram_wen/sram_waddr/sram_wdata  out  8/ADDR_W/DATA_W  SRAM byte-write enables, address, data

Function
REQ-003 Block SHALL be the AXI4 responder (INCR bursts, full 8-byte beats, OKAY responses only) for the core's AXI master, serving one transaction at a time.
REQ-004 FSM states SHALL be IDLE, WR_DATA, WR_RESP, RD_REQ, RD_RESP.
REQ-005 awready/arready SHALL be high only in IDLE; handshake captures id, addr with low 3 bits cleared, len; beat counter cleared.
REQ-006 When awvalid and arvalid are both high in IDLE, only one SHALL be accepted, by round-robin (priority flips after each grant; read first after reset).
REQ-007 AW accept -> WR_DATA; AR accept -> RD_REQ (next cycle).
REQ-008 In WR_DATA, wready SHALL be 1; each wvalid&wready beat drives sram_wen=wstrb, sram_waddr=current addr, sram_wdata=wdata combinationally in the same cycle; sram_wen=0 otherwise.
REQ-009 Address SHALL advance by 8 per beat, wrapping modulo 2^ADDR_W; 4 KB boundaries are not checked.
REQ-010 Burst end SHALL be decided by counter==len, not wlast; wlast mismatch is ignored; final beat -> WR_RESP.
REQ-011 WR_RESP SHALL hold bvalid=1, bid=captured id until bready, then IDLE.
REQ-012 RD_REQ SHALL assert sram_ren=1, sram_raddr=current addr for one cycle, then RD_RESP.
REQ-013 RD_RESP SHALL hold rvalid=1, rdata=sram_rdata, rid=captured id, rlast=(counter==len) until rready; on handshake: last beat -> IDLE, else advance address/counter -> RD_REQ.
REQ-014 Read latency: AR handshake cycle T -> sram_ren at T+1 -> rvalid at T+2; beats every 2 cycles with rready=1.
REQ-015 len=255 SHALL yield exactly 256 beats (8-bit counter, no overflow).
REQ-016 Valid outputs SHALL never drop before their handshake completes.

Reset
REQ-017 On reset: state IDLE, awready=arready=wready=bvalid=rvalid=0, sram_ren=0, sram_wen=0, captured regs 0, priority=read; the reset cycle itself drives these.
REQ-018 Reset mid-burst SHALL abandon the transaction with no further SRAM access or response.

Structure
REQ-019 State encoding, AXI widths and beat byte count SHALL live in the shared ysyx_22041752 header/package.
REQ-020 Single module; no sub-module required.

Verification
REQ-021 Single write: awaddr=0x8000_0010, awlen=0, wdata=0x1122334455667788, wstrb=0x0F -> one cycle sram_wen=0x0F, sram_waddr=0x8000_0010; bvalid, bid=awid.
REQ-022 Read burst: araddr=0x8000_0000, arlen=3, rready=1 -> sram_raddr 0x..00,08,10,18; 4 beats every 2 cycles, rlast on 4th only, rid=arid.
REQ-023 Backpressure: rready low 5 cycles on beat 1 -> rvalid/rdata stable, no extra sram_ren.
REQ-024 Simultaneous awvalid and arvalid after reset -> read granted first; next simultaneous pair -> write granted.
REQ-025 awlen=255 with wlast only on beat 10 -> 256 SRAM writes, single bvalid after beat 256.
REQ-026 reset asserted mid read burst (beat 2 of 4) -> next cycle rvalid=0, sram_ren=0, IDLE, arready=1 following cycle.
